// File: rtl/xbar_scatter_accum_pkg.sv
// Shared constants and bundle types for the product scatter/accumulate crossbar.
// Batch struct extends the multiplier-to-crossbar bundle with per-lane coordinates.
package xbar_scatter_accum_pkg;

    localparam int N    = 16;
    localparam int PW   = 32;
    localparam int ACCW = 32;
    localparam int B    = 32;
    localparam int D    = 8;

    localparam int BW = $clog2(B);
    localparam int DW = $clog2(D);
    localparam int AW = BW + DW;
    localparam int IW = $clog2(B * D);

    typedef enum logic [1:0] {
        ACCUM,
        FLUSH,
        DRAIN
    } state_e;

    typedef struct packed {
        logic [N-1:0][PW-1:0] data;
        logic [N-1:0]         valid;
    } mul_batch_t;

    typedef struct packed {
        mul_batch_t           prod;
        logic [N-1:0][AW-1:0] addr;
    } batch_t;

    typedef struct packed {
        logic            valid;
        logic [IW-1:0]   index;
        logic [ACCW-1:0] data;
    } rdout_t;

endpackage

// File: rtl/xbar_bank_arbiter.sv
// Fixed-priority (lowest lane wins) selector for one accumulator bank.
// Ports: mask_i/addr_i/data_i pending lanes; grant_o one-hot, hit_o, entry_o/data_o of winner.
module xbar_bank_arbiter
    import xbar_scatter_accum_pkg::*;
#(
    parameter int BANK = 0
) (
    input  logic [N-1:0]         mask_i,
    input  logic [N-1:0][AW-1:0] addr_i,
    input  logic [N-1:0][PW-1:0] data_i,
    output logic [N-1:0]         grant_o,
    output logic                 hit_o,
    output logic [DW-1:0]        entry_o,
    output logic [PW-1:0]        data_o
);

    logic [N-1:0] req;

    always_comb begin
        req = '0;
        for (int i = 0; i < N; i++) begin
            req[i] = mask_i[i] && (addr_i[i][BW-1:0] == BW'(BANK));
        end
    end

    // Isolate the lowest set request bit.
    assign grant_o = req & (~req + N'(1));
    assign hit_o   = |req;

    always_comb begin
        entry_o = '0;
        data_o  = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_o[i]) begin
                entry_o = entry_o | addr_i[i][AW-1:BW];
                data_o  = data_o | data_i[i];
            end
        end
    end

endmodule

// File: rtl/xbar_scatter_accum.sv
// Scatters product batches into B accumulator banks, then streams and clears them.
// Ports: in_* batch handshake, drain_req, out_* read-out stream, drain_done pulse.
module xbar_scatter_accum
    import xbar_scatter_accum_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      in_valid,
    input  logic [N*PW-1:0]   in_data,
    input  logic [N*AW-1:0]   in_addr,
    output logic              in_ready,
    input  logic              drain_req,
    output logic              out_valid,
    output logic [ACCW-1:0]   out_data,
    output logic [IW-1:0]     out_index,
    input  logic              out_ready,
    output logic              drain_done
);

    batch_t          pend_q;
    logic [N-1:0]    mask_q, mask_d;
    state_e          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic            done_q, done_d;
    logic [ACCW-1:0] acc_q [B*D];

    logic [N-1:0]    grant [B];
    logic [B-1:0]    hit;
    logic [DW-1:0]   entry [B];
    logic [PW-1:0]   bdata [B];
    logic [IW-1:0]   widx  [B];
    logic [N-1:0]    served;
    logic [N-1:0]    live;
    logic            accept;
    logic            hs;
    rdout_t          rd;

    assign live = mask_q & pend_q.prod.valid;

    for (genvar g = 0; g < B; g++) begin : g_bank
        xbar_bank_arbiter #(
            .BANK (g)
        ) u_arb (
            .mask_i  (live),
            .addr_i  (pend_q.addr),
            .data_i  (pend_q.prod.data),
            .grant_o (grant[g]),
            .hit_o   (hit[g]),
            .entry_o (entry[g]),
            .data_o  (bdata[g])
        );
        // Flat index layout is bank*D + entry.
        assign widx[g] = {BW'(g), entry[g]};
    end

    always_comb begin
        served = '0;
        for (int b = 0; b < B; b++) begin
            served = served | grant[b];
        end
    end

    // Ready as soon as this cycle empties the pending stage: no bubble.
    assign in_ready = (state_q == ACCUM) && ((live & ~served) == '0);
    assign accept   = in_ready && (|in_valid);
    assign mask_d   = accept ? in_valid : (live & ~served);
    assign hs       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
            mask_q <= '0;
        end else begin
            mask_q <= mask_d;
            if (accept) begin
                pend_q.prod.data  <= in_data;
                pend_q.prod.valid <= in_valid;
                pend_q.addr       <= in_addr;
            end
        end
    end

    // Scatter updates and drain clears never coincide: the pending
    // stage is empty before DRAIN is entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < B * D; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            for (int b = 0; b < B; b++) begin
                if (hit[b]) begin
                    acc_q[widx[b]] <= acc_q[widx[b]] + ACCW'(bdata[b]);
                end
            end
            if (hs) begin
                acc_q[ptr_q] <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCUM;
            ptr_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        done_d  = 1'b0;
        unique case (state_q)
            ACCUM: begin
                if (drain_req) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (mask_q == '0) begin
                    state_d = DRAIN;
                    ptr_d   = '0;
                end
            end
            DRAIN: begin
                if (hs) begin
                    ptr_d = ptr_q + IW'(1);
                    if (ptr_q == IW'(B * D - 1)) begin
                        state_d = ACCUM;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    always_comb begin
        rd = '0;
        if (state_q == DRAIN) begin
            rd.valid = 1'b1;
            rd.index = ptr_q;
            rd.data  = acc_q[ptr_q];
        end
    end

    assign out_valid  = rd.valid;
    assign out_index  = rd.index;
    assign out_data   = rd.data;
    assign drain_done = done_q;

endmodule

// File: tb/tb_xbar_scatter_accum.sv
// Directed table-driven bench for xbar_scatter_accum.
// Batches are scattered, drained, and the read-out image compared to hand values.
module tb_xbar_scatter_accum;

    logic         clk = 1'b0;
    logic         rst;
    logic [15:0]  in_valid;
    logic [511:0] in_data;
    logic [127:0] in_addr;
    logic         in_ready;
    logic         drain_req;
    logic         out_valid;
    logic [31:0]  out_data;
    logic [7:0]   out_index;
    logic         out_ready;
    logic         drain_done;

    xbar_scatter_accum dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_addr    (in_addr),
        .in_ready   (in_ready),
        .drain_req  (drain_req),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_index  (out_index),
        .out_ready  (out_ready),
        .drain_done (drain_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]       valid;
        logic [15:0][31:0] data;
        logic [15:0][7:0]  addr;
        int                nb;
        int                stall;
        int                idx;
        logic [31:0]       val;
        int                nz;
        logic [31:0]       sum;
    } vec_t;

    vec_t        tv [5];
    logic [31:0] rdw [256];
    int          npass = 0;
    int          ntot  = 0;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        ntot++;
        if (a === e) npass++;
        else $display("FAIL %s: got %0h expected %0h", n, a, e);
    endtask

    // All tasks start and end just after a falling edge.
    task automatic send(input logic [15:0] v, input logic [511:0] d,
                        input logic [127:0] a, output int stall);
        int w;
        w = 0;
        stall = 0;
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("ready_before_send", 64'(in_ready), 64'd1);
        in_valid = v;
        in_data  = d;
        in_addr  = a;
        @(negedge clk);
        in_valid = '0;
        in_data  = '0;
        in_addr  = '0;
        while (!in_ready && stall < 200) begin
            stall++;
            @(negedge clk);
        end
    endtask

    task automatic drain(input bit pulse, input bit bp,
                         output int words, output int dones, output int errs);
        int          cyc;
        int          post;
        bit          held;
        logic [7:0]  pidx;
        logic [31:0] pdat;
        words = 0;
        dones = 0;
        errs  = 0;
        cyc   = 0;
        post  = 0;
        held  = 0;
        pidx  = '0;
        pdat  = '0;
        for (int i = 0; i < 256; i++) rdw[i] = 32'hxxxx_xxxx;
        if (pulse) begin
            drain_req = 1'b1;
            @(negedge clk);
            drain_req = 1'b0;
        end
        while (cyc < 3000 && post < 4) begin
            out_ready = bp ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
            if (drain_done) dones++;
            if (dones > 0) post++;
            if (out_valid) begin
                if (held && (out_index !== pidx || out_data !== pdat)) errs++;
                if (32'(out_index) != words) errs++;
                if (out_ready) begin
                    if (words < 256) rdw[words] = out_data;
                    words++;
                    held = 0;
                end else begin
                    held = 1;
                    pidx = out_index;
                    pdat = out_data;
                end
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b1;
    endtask

    task automatic image(output int nz, output logic [31:0] sum);
        nz  = 0;
        sum = '0;
        for (int i = 0; i < 256; i++) begin
            if (rdw[i] !== 32'd0) nz++;
            sum = sum + rdw[i];
        end
    endtask

    task automatic drain_zero(input string n);
        int          w, dn, er, nz;
        logic [31:0] s;
        drain(1, 0, w, dn, er);
        image(nz, s);
        chk({n, "_words"}, 64'(w), 64'd256);
        chk({n, "_done"}, 64'(dn), 64'd1);
        chk({n, "_nz"}, 64'(nz), 64'd0);
    endtask

    initial begin
        int          st, tot, w, dn, er, nz, cnt;
        logic [31:0] s;

        for (int i = 0; i < 16; i++) begin
            tv[0].data[i] = 32'(i + 1);
            tv[0].addr[i] = 8'(i);
        end
        tv[0].valid = 16'hFFFF; tv[0].nb = 1; tv[0].stall = 0;
        tv[0].idx = 120; tv[0].val = 32'd16; tv[0].nz = 16; tv[0].sum = 32'd136;

        for (int i = 0; i < 16; i++) begin
            tv[1].data[i] = 32'd5;
            tv[1].addr[i] = 8'h43;
        end
        tv[1].valid = 16'hFFFF; tv[1].nb = 1; tv[1].stall = 15;
        tv[1].idx = 26; tv[1].val = 32'd80; tv[1].nz = 1; tv[1].sum = 32'd80;

        for (int i = 0; i < 16; i++) begin
            tv[2].data[i] = 32'hDEAD_BEEF;
            tv[2].addr[i] = 8'(i * 7);
        end
        tv[2].data[0] = 32'd7; tv[2].addr[0] = 8'h20;
        tv[2].data[2] = 32'd9; tv[2].addr[2] = 8'h20;
        tv[2].valid = 16'h0005; tv[2].nb = 1; tv[2].stall = 1;
        tv[2].idx = 1; tv[2].val = 32'd16; tv[2].nz = 1; tv[2].sum = 32'd16;

        tv[3].data = '0;
        tv[3].addr = '0;
        tv[3].data[0] = 32'hFFFF_FFFF; tv[3].addr[0] = 8'h01;
        tv[3].valid = 16'h0001; tv[3].nb = 2; tv[3].stall = 0;
        tv[3].idx = 8; tv[3].val = 32'hFFFF_FFFE; tv[3].nz = 1; tv[3].sum = 32'hFFFF_FFFE;

        tv[4].data = '0;
        tv[4].addr = '0;
        for (int i = 0; i < 4; i++) begin
            tv[4].data[i] = 32'((i + 1) * 10);
            tv[4].addr[i] = 8'((i << 5) | 7);
        end
        tv[4].data[4] = 32'd1; tv[4].addr[4] = 8'h07;
        tv[4].data[5] = 32'd2; tv[4].addr[5] = 8'h07;
        tv[4].valid = 16'h003F; tv[4].nb = 1; tv[4].stall = 5;
        tv[4].idx = 56; tv[4].val = 32'd13; tv[4].nz = 4; tv[4].sum = 32'd103;

        rst       = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        in_addr   = '0;
        drain_req = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_index", 64'(out_index), 64'd0);
        chk("rst_drain_done", 64'(drain_done), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 5; k++) begin
            tot = 0;
            for (int b = 0; b < tv[k].nb; b++) begin
                send(tv[k].valid, tv[k].data, tv[k].addr, st);
                tot += st;
            end
            chk($sformatf("v%0d_stall", k), 64'(tot), 64'(tv[k].stall));
            drain(1, 0, w, dn, er);
            image(nz, s);
            chk($sformatf("v%0d_words", k), 64'(w), 64'd256);
            chk($sformatf("v%0d_done", k), 64'(dn), 64'd1);
            chk($sformatf("v%0d_order", k), 64'(er), 64'd0);
            chk($sformatf("v%0d_val", k), 64'(rdw[tv[k].idx]), 64'(tv[k].val));
            chk($sformatf("v%0d_nz", k), 64'(nz), 64'(tv[k].nz));
            chk($sformatf("v%0d_sum", k), 64'(s), 64'(tv[k].sum));
        end

        // Drain under out_ready pattern 1,0,0,1, then a clean re-drain.
        send(tv[0].valid, tv[0].data, tv[0].addr, st);
        drain(1, 1, w, dn, er);
        image(nz, s);
        chk("bp_words", 64'(w), 64'd256);
        chk("bp_done", 64'(dn), 64'd1);
        chk("bp_order_hold", 64'(er), 64'd0);
        chk("bp_bank5", 64'(rdw[40]), 64'd6);
        chk("bp_bank15", 64'(rdw[120]), 64'd16);
        chk("bp_nz", 64'(nz), 64'd16);
        drain_zero("redrain");

        // Batch accepted in the same cycle as drain_req.
        while (!in_ready) @(negedge clk);
        in_valid  = tv[1].valid;
        in_data   = tv[1].data;
        in_addr   = tv[1].addr;
        drain_req = 1'b1;
        @(negedge clk);
        in_valid  = '0;
        in_data   = '0;
        in_addr   = '0;
        drain_req = 1'b0;
        chk("flush_not_ready", 64'(in_ready), 64'd0);
        drain(0, 0, w, dn, er);
        image(nz, s);
        chk("same_cyc_words", 64'(w), 64'd256);
        chk("same_cyc_val", 64'(rdw[26]), 64'd80);
        chk("same_cyc_nz", 64'(nz), 64'd1);

        // Reset while the read pointer sits at 40.
        send(tv[0].valid, tv[0].data, tv[0].addr, st);
        drain_req = 1'b1;
        @(negedge clk);
        drain_req = 1'b0;
        cnt = 0;
        while (!(out_valid && out_index == 8'd40) && cnt < 400) begin
            @(negedge clk);
            cnt++;
        end
        chk("reach_ptr40", 64'(out_index), 64'd40);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_out_valid", 64'(out_valid), 64'd0);
        chk("rstmid_in_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (drain_done) cnt++;
            @(negedge clk);
        end
        chk("rstmid_no_done", 64'(cnt), 64'd0);
        drain_zero("post_rst");

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/xbar_scatter_accum.md
Name: xbar_scatter_accum

Overview:
- Receiving end of the multiplier-to-crossbar interface: it takes each cycle's batch of N = F*I products, with per-lane valid bits and output coordinates.
- It scatters the products to B accumulator banks, serialising bank conflicts by fixed priority and back-pressuring the multiplier array while conflicts drain.
- On request, it streams the accumulated partial sums out and clears them, ready for the next output tile.

Parameters:
- N, 16, product lanes per batch (F*I with F=I=4).
- PW, 32, product width in bits (16x16 unsigned multiply).
- ACCW, 32, accumulator width in bits.
- B, 32, number of accumulator banks (power of two).
- D, 8, entries per bank (power of two).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  N  per-lane product valid
- in_data  in  N*PW  per-lane product
- in_addr  in  N*(log2 B + log2 D)  per-lane coordinate; low log2 B bits select the bank, high log2 D bits select the entry
- in_ready  out  1  batch accepted this cycle when high
- drain_req  in  1  single-cycle pulse: flush and read out all entries
- out_valid  out  1  read-out word valid
- out_data  out  ACCW  accumulated value
- out_index  out  log2(B*D)  flat index, bank*D + entry
- out_ready  in  1  downstream accepts the read-out word
- drain_done  out  1  one-cycle pulse after the last word is accepted

Behaviour:
- Reset (synchronous): all accumulators 0; pending mask 0; state ACCUM; in_ready=1; out_valid=0; out_data=0; out_index=0; drain_done=0.
- Batch accept:
  - A transfer occurs when in_ready=1 and any in_valid bit is set.
  - The batch (data, addr, valid) is registered into the pending stage; the pending mask is set to in_valid.
  - Lanes with valid=0 are never accumulated. An all-zero in_valid is ignored.
- Scatter:
  - Each cycle, for every bank, the lowest-index pending lane addressing that bank is served: acc[bank][entry] <= acc[bank][entry] + zero-extended product, wrapping modulo 2^ACCW.
  - Served lanes are cleared from the mask.
  - At most one update per bank per cycle; different banks update in parallel.
  - Two lanes with the same bank and same entry are served in consecutive cycles, lower index first; both contributions are kept.
- Latency: a batch with no bank conflicts is fully accumulated one cycle after acceptance. A k-way worst conflict takes k cycles.
- in_ready:
  - Combinationally 1 in ACCUM when the pending mask is empty, or when every remaining pending lane is served this cycle. This allows back-to-back batches with no bubble.
  - 0 in FLUSH and DRAIN.
- FSM:
  - ACCUM: normal operation. drain_req -> FLUSH. A batch accepted in the same cycle as drain_req is still taken and accumulated.
  - FLUSH: no new batches; the pending mask keeps draining. When the mask is empty -> DRAIN with the read pointer at 0.
  - DRAIN:
    - out_valid=1, out_index=ptr, out_data=acc at ptr.
    - On out_valid&&out_ready: that entry is cleared to 0 and ptr increments.
    - When ptr=B*D-1 is accepted: drain_done pulses next cycle, out_valid drops, state -> ACCUM.
    - out_data and out_index hold stable while out_ready=0.
  - drain_req outside ACCUM is ignored.
- Wrap-around: accumulation wraps silently; there is no saturation or overflow flag.
- Reset mid-operation: the pending batch is discarded, all accumulators clear, any drain aborts with no drain_done, and state returns to ACCUM.

Decomposition:
- Shared package:
  - Constants N, B, D, PW, ACCW.
  - Typedef of the product-batch struct (data, valid, addr per lane), extending the existing multiplier-to-crossbar struct with addr.
  - Typedef of the read-out struct.
- One sub-module, xbar_bank_arbiter: per-bank fixed-priority N-lane selector producing a one-hot grant and a served mask. Instantiated B times or as a generate loop.

Test Plan:
- No conflict:
  - Stimulus: lanes 0..15 valid, data=i+1, addr bank=i, entry=0.
  - Response: in_ready stays 1; after drain, indices bank*8 for banks 0..15 read 1..16, all other words read 0.
- Full conflict:
  - Stimulus: 16 lanes valid, all bank 3 entry 2, data=5.
  - Response: in_ready=0 for 15 cycles; after drain, index 26 reads 80.
- Partial valid:
  - Stimulus: in_valid=16'h0005, lane0 data=7, lane2 data=9, both bank 0 entry 1, other lanes with garbage data.
  - Response: index 1 reads 16, all others 0.
- Wrap:
  - Stimulus: two batches of 32'hFFFF_FFFF to bank 1 entry 0.
  - Response: index 8 reads 32'hFFFF_FFFE.
- Drain backpressure:
  - Stimulus: out_ready toggled 1,0,0,1.
  - Response: out_index advances only on handshake cycles; 256 words total; drain_done pulses once; second drain reads all zeros.
- Reset mid-drain:
  - Stimulus: rst asserted at ptr=40.
  - Response: next cycle out_valid=0, in_ready=1, no drain_done; a subsequent drain reads all zeros.
